// File: rtl/popcount_accum_ctrl_pkg.sv
// Shared constants for the popcount accumulate controller and its datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package popcount_accum_ctrl_pkg;

    localparam int POPCNT_WORD_W  = 64;
    localparam int POPCNT_CNT_W   = 7;
    localparam int PC_LATENCY_MIN = 0;
    localparam int PC_LATENCY_MAX = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_OUT   = 2'd3;

    function automatic logic [POPCNT_CNT_W-1:0] popcount_word(input logic [POPCNT_WORD_W-1:0] w);
        logic [POPCNT_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < POPCNT_WORD_W; i++) begin
            n = n + POPCNT_CNT_W'(w[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/popcount64.sv
// Pipelined 64-bit population count.
// Latency: LATENCY cycles from en to count (0 = combinational).
// Backpressure: none; the first stage loads only on en, so count holds the last result.
module popcount64
    import popcount_accum_ctrl_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     en,
    input  logic [POPCNT_WORD_W-1:0] data,
    output logic [POPCNT_CNT_W-1:0]  count
);

    logic [POPCNT_CNT_W-1:0] cnt_dat;

    assign cnt_dat = popcount_word(data);

    generate
        if (LATENCY == 0) begin : g_comb
            assign count = cnt_dat;
        end else begin : g_pipe
            logic [POPCNT_CNT_W-1:0] stage_dat [LATENCY];

            // Later stages are pure delays of the gated first stage, so a
            // result lands on count exactly LATENCY cycles after its en.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        stage_dat[i] <= '0;
                    end
                end else begin
                    if (en) begin
                        stage_dat[0] <= cnt_dat;
                    end
                    for (int i = 1; i < LATENCY; i++) begin
                        stage_dat[i] <= stage_dat[i-1];
                    end
                end
            end

            assign count = stage_dat[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/popcount_accum_ctrl.sv
// Issues a length-prefixed stream of 64-bit words into popcount64 and returns the summed count.
// Latency: last word accepted in cycle len, sum valid in cycle len+PC_LATENCY+1.
// Backpressure: s_ready only while words of the current vector remain; m_sum held until m_ready.
module popcount_accum_ctrl
    import popcount_accum_ctrl_pkg::*;
#(
    parameter int PC_LATENCY = 2,
    parameter int LEN_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [POPCNT_WORD_W-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [LEN_W+6:0]         m_sum,
    output logic                     busy
);

    localparam int ACC_W = LEN_W + 7;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    generate
        if (PC_LATENCY < PC_LATENCY_MIN || PC_LATENCY > PC_LATENCY_MAX) begin : g_bad_latency
            $error("popcount_accum_ctrl: PC_LATENCY must be within 0..3");
        end
    endgenerate

    state_t                  state;
    logic [LEN_W-1:0]        len;
    logic [LEN_W-1:0]        issued;
    logic [LEN_W-1:0]        retired;
    logic [ACC_W-1:0]        acc;
    logic                    issue;
    logic                    retire;
    logic [POPCNT_CNT_W-1:0] pc_count;

    assign s_ready = (state == ST_RUN) && (issued < len);
    assign issue   = s_ready && s_valid;
    assign m_valid = (state == ST_OUT);
    assign m_sum   = acc;
    assign busy    = (state != ST_IDLE);

    popcount64 #(
        .LATENCY (PC_LATENCY)
    ) u_popcount64 (
        .clk    (clk),
        .arst_n (~rst),
        .en     (issue),
        .data   (s_data),
        .count  (pc_count)
    );

    generate
        if (PC_LATENCY == 0) begin : g_no_vsr
            assign retire = issue;
        end else begin : g_vsr
            logic [PC_LATENCY-1:0] vsr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vsr <= '0;
                end else begin
                    vsr[0] <= issue;
                    for (int i = 1; i < PC_LATENCY; i++) begin
                        vsr[i] <= vsr[i-1];
                    end
                end
            end

            assign retire = vsr[PC_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            len     <= '0;
            issued  <= '0;
            retired <= '0;
            acc     <= '0;
        end else begin
            if (issue) begin
                issued <= issued + LEN_ONE;
            end
            if (retire) begin
                retired <= retired + LEN_ONE;
                acc     <= acc + ACC_W'(pc_count);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        issued  <= '0;
                        retired <= '0;
                        if (cfg_len != '0) begin
                            len   <= cfg_len;
                            state <= ST_RUN;
                        end else begin
                            state <= ST_OUT;
                        end
                    end
                end
                ST_RUN: begin
                    // Only a zero-latency datapath can retire the last word while still in RUN.
                    if (retire && (retired + LEN_ONE == len)) begin
                        state <= ST_OUT;
                    end else if (issue && (issued + LEN_ONE == len)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (retire && (retired + LEN_ONE == len)) begin
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_accum_ctrl.sv
// Directed bench for popcount_accum_ctrl across latencies 0, 2, 3 and a narrow length field.
// Latency: n/a.  Backpressure: m_ready held low in one scenario, bubbles on s_valid in another.
module tb_popcount_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_len;
    logic        s_valid;
    logic [63:0] s_data;
    logic        m_ready;

    logic        s_ready_l2, m_valid_l2, busy_l2;
    logic [22:0] m_sum_l2;
    logic        s_ready_l0, m_valid_l0, busy_l0;
    logic [22:0] m_sum_l0;
    logic        s_ready_l3, m_valid_l3, busy_l3;
    logic [22:0] m_sum_l3;
    logic        s_ready_w4, m_valid_w4, busy_w4;
    logic [10:0] m_sum_w4;

    always #5 clk = ~clk;

    popcount_accum_ctrl u_l2 (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .s_valid(s_valid), .s_ready(s_ready_l2), .s_data(s_data),
        .m_valid(m_valid_l2), .m_ready(m_ready), .m_sum(m_sum_l2), .busy(busy_l2)
    );

    popcount_accum_ctrl #(.PC_LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .s_valid(s_valid), .s_ready(s_ready_l0), .s_data(s_data),
        .m_valid(m_valid_l0), .m_ready(m_ready), .m_sum(m_sum_l0), .busy(busy_l0)
    );

    popcount_accum_ctrl #(.PC_LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .s_valid(s_valid), .s_ready(s_ready_l3), .s_data(s_data),
        .m_valid(m_valid_l3), .m_ready(m_ready), .m_sum(m_sum_l3), .busy(busy_l3)
    );

    popcount_accum_ctrl #(.PC_LATENCY(2), .LEN_W(4)) u_w4 (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len[3:0]),
        .s_valid(s_valid), .s_ready(s_ready_w4), .s_data(s_data),
        .m_valid(m_valid_w4), .m_ready(m_ready), .m_sum(m_sum_w4), .busy(busy_w4)
    );

    // sel: 0 = latency 2, 1 = latency 0, 2 = latency 3, 3 = LEN_W 4
    int          sel;
    logic        cur_s_ready, cur_m_valid, cur_busy;
    logic [22:0] cur_m_sum;

    always_comb begin
        cur_s_ready = s_ready_l2;
        cur_m_valid = m_valid_l2;
        cur_busy    = busy_l2;
        cur_m_sum   = m_sum_l2;
        case (sel)
            1: begin
                cur_s_ready = s_ready_l0; cur_m_valid = m_valid_l0;
                cur_busy = busy_l0; cur_m_sum = m_sum_l0;
            end
            2: begin
                cur_s_ready = s_ready_l3; cur_m_valid = m_valid_l3;
                cur_busy = busy_l3; cur_m_sum = m_sum_l3;
            end
            3: begin
                cur_s_ready = s_ready_w4; cur_m_valid = m_valid_w4;
                cur_busy = busy_w4; cur_m_sum = {12'd0, m_sum_w4};
            end
            default: ;
        endcase
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] words [16];
    int          nwords;
    int          ign_cycle;
    int          accepted;
    logic        mv_log   [64];
    logic        busy_log [64];
    logic        sr_log   [64];
    logic [22:0] sum_log  [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; cfg_len = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        ign_cycle = -1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Cycle 0 presents start; cycles 1..ncyc offer words back-to-back with m_ready high.
    task automatic run_vec(input int len, input int ncyc);
        logic hs;
        accepted = 0;
        start = 1'b1; cfg_len = 16'(len); s_valid = 1'b0; m_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            mv_log[c] = cur_m_valid; busy_log[c] = cur_busy;
            sr_log[c] = cur_s_ready; sum_log[c] = cur_m_sum;
            if (c == ign_cycle) begin
                start = 1'b1; cfg_len = '0;
            end else begin
                start = 1'b0;
            end
            if (accepted < nwords) begin
                s_valid = 1'b1; s_data = words[accepted];
            end else begin
                s_valid = 1'b0; s_data = '0;
            end
            hs = s_valid && cur_s_ready;
            tick();
            if (hs) accepted++;
        end
        start = 1'b0; s_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 4; d++) begin
            sel = d;
            #1;
            n_vec++; if (cur_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy dut%0d: got %0b expected 0", d, cur_busy); end
            n_vec++; if (cur_s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready dut%0d: got %0b expected 0", d, cur_s_ready); end
            n_vec++; if (cur_m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid dut%0d: got %0b expected 0", d, cur_m_valid); end
            n_vec++; if (cur_m_sum !== 23'd0) begin n_err++; $display("FAIL reset_m_sum dut%0d: got %0d expected 0", d, cur_m_sum); end
        end
    endtask

    task automatic test_basic();
        do_reset();
        sel = 0;
        words[0] = 64'hFFFF_FFFF_FFFF_FFFF; words[1] = 64'h0000_0000_0000_000F; words[2] = 64'h0;
        nwords = 3;
        run_vec(3, 9);
        for (int c = 1; c <= 9; c++) begin
            n_vec++;
            if (mv_log[c] !== (c == 6)) begin
                n_err++; $display("FAIL basic_m_valid c%0d: got %0b expected %0b", c, mv_log[c], (c == 6));
            end
        end
        n_vec++; if (sum_log[6] !== 23'd68) begin n_err++; $display("FAIL basic_m_sum: got %0d expected 68", sum_log[6]); end
        n_vec++; if (busy_log[1] !== 1'b1) begin n_err++; $display("FAIL basic_busy_c1: got %0b expected 1", busy_log[1]); end
        n_vec++; if (sr_log[1] !== 1'b1) begin n_err++; $display("FAIL basic_s_ready_c1: got %0b expected 1", sr_log[1]); end
        n_vec++; if (sr_log[4] !== 1'b0) begin n_err++; $display("FAIL basic_s_ready_c4: got %0b expected 0", sr_log[4]); end
        n_vec++; if (busy_log[7] !== 1'b0) begin n_err++; $display("FAIL basic_busy_c7: got %0b expected 0", busy_log[7]); end
        n_vec++; if (accepted !== 3) begin n_err++; $display("FAIL basic_accepted: got %0d expected 3", accepted); end
    endtask

    task automatic test_latency(input int d, input int exp_cyc);
        do_reset();
        sel = d;
        words[0] = 64'h8000_0000_0000_0001;
        nwords = 1;
        run_vec(1, 8);
        for (int c = 1; c <= 8; c++) begin
            n_vec++;
            if (mv_log[c] !== (c == exp_cyc)) begin
                n_err++; $display("FAIL latency_m_valid dut%0d c%0d: got %0b expected %0b", d, c, mv_log[c], (c == exp_cyc));
            end
        end
        n_vec++; if (sum_log[exp_cyc] !== 23'd2) begin n_err++; $display("FAIL latency_m_sum dut%0d: got %0d expected 2", d, sum_log[exp_cyc]); end
    endtask

    task automatic test_bubbles();
        logic [11:0] pat;
        logic        hs;
        logic        seen;
        int          got;
        do_reset();
        sel = 0;
        pat = 12'b0110_1100_1011;
        got = 0; seen = 1'b0;
        start = 1'b1; cfg_len = 16'd4; m_ready = 1'b0;
        tick();
        start = 1'b0;
        s_data = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (cur_m_valid) begin
                seen = 1'b1;
            end else begin
                if (got == 4) begin
                    n_vec++; if (cur_s_ready !== 1'b0) begin n_err++; $display("FAIL bubbles_s_ready_after_last c%0d: got %0b expected 0", c, cur_s_ready); end
                end
                s_valid = (c <= 12) ? pat[c-1] : 1'b1;
                hs = s_valid && cur_s_ready;
                tick();
                if (hs) got++;
            end
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL bubbles_timeout: got no m_valid expected m_valid within 40 cycles"); end
        s_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_vec++; if (cur_m_valid !== 1'b1) begin n_err++; $display("FAIL bubbles_hold_m_valid k%0d: got %0b expected 1", k, cur_m_valid); end
            n_vec++; if (cur_m_sum !== 23'd256) begin n_err++; $display("FAIL bubbles_hold_m_sum k%0d: got %0d expected 256", k, cur_m_sum); end
            n_vec++; if (cur_s_ready !== 1'b0) begin n_err++; $display("FAIL bubbles_out_s_ready k%0d: got %0b expected 0", k, cur_s_ready); end
            hs = s_valid && cur_s_ready;
            tick();
            if (hs) got++;
        end
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        n_vec++; if (cur_m_valid !== 1'b0) begin n_err++; $display("FAIL bubbles_after_ack_m_valid: got %0b expected 0", cur_m_valid); end
        n_vec++; if (cur_busy !== 1'b0) begin n_err++; $display("FAIL bubbles_after_ack_busy: got %0b expected 0", cur_busy); end
        n_vec++; if (got !== 4) begin n_err++; $display("FAIL bubbles_accepted: got %0d expected 4", got); end
    endtask

    task automatic test_empty_and_ignore();
        do_reset();
        sel = 0;
        nwords = 0;
        run_vec(0, 3);
        n_vec++; if (mv_log[1] !== 1'b1) begin n_err++; $display("FAIL empty_m_valid_c1: got %0b expected 1", mv_log[1]); end
        n_vec++; if (sum_log[1] !== 23'd0) begin n_err++; $display("FAIL empty_m_sum: got %0d expected 0", sum_log[1]); end
        n_vec++; if (mv_log[2] !== 1'b0) begin n_err++; $display("FAIL empty_m_valid_c2: got %0b expected 0", mv_log[2]); end
        n_vec++; if (busy_log[2] !== 1'b0) begin n_err++; $display("FAIL empty_busy_c2: got %0b expected 0", busy_log[2]); end
        words[0] = 64'h0000_0000_0000_00FF; words[1] = 64'h0000_0000_0000_0003;
        nwords = 2;
        ign_cycle = 2;
        run_vec(2, 8);
        ign_cycle = -1;
        for (int c = 1; c <= 8; c++) begin
            n_vec++;
            if (mv_log[c] !== (c == 5)) begin
                n_err++; $display("FAIL ignore_m_valid c%0d: got %0b expected %0b", c, mv_log[c], (c == 5));
            end
        end
        n_vec++; if (sum_log[5] !== 23'd10) begin n_err++; $display("FAIL ignore_m_sum: got %0d expected 10", sum_log[5]); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        sel = 2;
        start = 1'b1; cfg_len = 16'd4; m_ready = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        tick();
        s_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (cur_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %0b expected 0", cur_busy); end
        n_vec++; if (cur_m_valid !== 1'b0) begin n_err++; $display("FAIL midrst_m_valid: got %0b expected 0", cur_m_valid); end
        n_vec++; if (cur_s_ready !== 1'b0) begin n_err++; $display("FAIL midrst_s_ready: got %0b expected 0", cur_s_ready); end
        n_vec++; if (cur_m_sum !== 23'd0) begin n_err++; $display("FAIL midrst_m_sum: got %0d expected 0", cur_m_sum); end
        words[0] = 64'h1;
        nwords = 1;
        run_vec(1, 7);
        for (int c = 1; c <= 7; c++) begin
            n_vec++;
            if (mv_log[c] !== (c == 5)) begin
                n_err++; $display("FAIL midrst_next_m_valid c%0d: got %0b expected %0b", c, mv_log[c], (c == 5));
            end
        end
        n_vec++; if (sum_log[5] !== 23'd1) begin n_err++; $display("FAIL midrst_next_m_sum: got %0d expected 1", sum_log[5]); end
    endtask

    task automatic test_max_len();
        do_reset();
        sel = 3;
        for (int i = 0; i < 15; i++) words[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        nwords = 15;
        run_vec(15, 20);
        for (int c = 1; c <= 20; c++) begin
            n_vec++;
            if (mv_log[c] !== (c == 18)) begin
                n_err++; $display("FAIL maxlen_m_valid c%0d: got %0b expected %0b", c, mv_log[c], (c == 18));
            end
        end
        n_vec++; if (sum_log[18] !== 23'd960) begin n_err++; $display("FAIL maxlen_m_sum: got %0d expected 960", sum_log[18]); end
        n_vec++; if (accepted !== 15) begin n_err++; $display("FAIL maxlen_accepted: got %0d expected 15", accepted); end
    endtask

    initial begin
        sel = 0;
        nwords = 0;
        ign_cycle = -1;
        test_reset();
        test_basic();
        test_latency(1, 2);
        test_latency(2, 5);
        test_bubbles();
        test_empty_and_ignore();
        test_reset_inflight();
        test_max_len();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/popcount_accum_ctrl.md
# popcount_accum_ctrl

Sequencing controller for the 64-bit popcount datapath used in the binarized convolution path. It accepts one vector-length command and then a stream of 64-bit words, and issues each accepted word into a `popcount64` instance. It tracks in-flight results through the popcount pipeline, accumulates them into a single per-vector sum, and returns that sum on a valid/ready output. The block sits between the operand fetch stream and the accumulation/threshold stage.

## Interface
Parameters:
- `PC_LATENCY`, default 2: latency of the `popcount64` instance (legal 0–3).
- `LEN_W`, default 16: width of the vector-length field in words.
- `ACC_W`, fixed at `LEN_W+7`: sum width (localparam, not overridable). Overflow is impossible.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `start`, in, 1: command strobe. Sampled only in IDLE.
- `cfg_len`, in, LEN_W: words per vector. Latched on an accepted `start`.
- `s_valid`, in, 1: input word valid.
- `s_ready`, out, 1: input word accepted when `s_valid && s_ready`.
- `s_data`, in, 64: input word.
- `m_valid`, out, 1: sum valid.
- `m_ready`, in, 1: downstream accepts the sum.
- `m_sum`, out, ACC_W: popcount total of the vector.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- FSM states are IDLE, RUN, DRAIN and OUT.
- **IDLE**
  - `start=1` with `cfg_len>0`: latch length, clear `issued`, `retired` and accumulator, go to RUN.
  - `start=1` with `cfg_len=0`: clear accumulator, go to OUT. The vector is empty and the sum is 0.
- **RUN**
  - `s_ready=1` while `issued<len`.
  - Each handshake drives the popcount `en=1` with `s_data` and increments `issued`.
  - When the handshake makes `issued==len`, go to DRAIN.
  - `s_ready` is never high in DRAIN or OUT, so extra words are not consumed.
- **Valid tracking**
  - A PC_LATENCY-deep valid shift register carries the issue strobe.
  - When the tap is high, a result retires: add the zero-extended popcount to the accumulator and increment `retired`.
  - The popcount output register holds its value when `en=0`, so the tap alone qualifies retirement. The datapath output is never used as a qualifier.
  - With PC_LATENCY=0, retirement happens in the issue cycle.
- **DRAIN**
  - When the retirement that makes `retired==len` occurs, go to OUT.
  - If that retirement happens in RUN (only possible with latency 0), go directly RUN→OUT.
- **OUT**
  - `m_valid=1` and `m_sum` equals the accumulator. Both are held stable until `m_ready`.
  - On handshake, go to IDLE with `m_valid=0` on the next cycle.
- `start` outside IDLE is ignored. It is not queued.
- `rst` in any state:
  - Next cycle is IDLE.
  - Valid shift register, counters and accumulator clear.
  - In-flight popcounts are discarded.
  - Outputs return to reset values.
- The `popcount64` reset pin is driven with `~rst`.

## Timing
- Reset values: `s_ready=0`, `m_valid=0`, `m_sum=0`, `busy=0`.
- Let cycle 0 be the cycle `start` is sampled in IDLE:
  - `busy=1` and `s_ready=1` from cycle 1.
  - With back-to-back words, the last word is accepted in cycle `len`.
  - The last word retires in cycle `len+PC_LATENCY`.
  - `m_valid=1` from cycle `len+PC_LATENCY+1`.
- Input bubbles (`s_valid=0`) delay only issue. Retirement count stays exact.
- Empty vector (`cfg_len=0`): `m_valid=1` in cycle 1.
- `m_ready` held high in OUT: a one-cycle `m_valid` pulse, then IDLE. The earliest next `start` is accepted in the IDLE cycle after that.
- Throughput: one word per cycle. Per-vector overhead is `PC_LATENCY+2` cycles.
- Retirement and issue can both occur in the same cycle; both counters update independently.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE/RUN/DRAIN/OUT);
  - `POPCNT_WORD_W=64`;
  - the legal PC_LATENCY range constants.
- An elaboration check rejects PC_LATENCY outside 0–3.
- The only sub-module is the existing `popcount64`, instantiated once with `.LATENCY(PC_LATENCY)`.
- Counters, valid shift register and FSM are local. No further sub-module is needed.

## Test plan
- PC_LATENCY=2, `cfg_len=3`, words `0xFFFF_FFFF_FFFF_FFFF`, `0x0000_0000_0000_000F`, `0` back-to-back, `m_ready=1` → `m_sum=68`, `m_valid` in cycle 6 only, `busy` low in cycle 7.
- PC_LATENCY=0 and 3, `cfg_len=1`, word `0x8000_0000_0000_0001` → `m_sum=2`, with `m_valid` in cycle 2 and cycle 5 respectively.
- `cfg_len=4`, all-ones words, random `s_valid` bubbles, `m_ready` low for 5 cycles in OUT:
  - `m_sum=256` held stable while waiting;
  - `s_ready=0` after the 4th word;
  - a 5th offered word is not consumed.
- `cfg_len=0` → `m_valid` in cycle 1, `m_sum=0`. A `start` pulsed during RUN of another vector is ignored, and that vector's sum is unaffected.
- `rst` asserted while 2 words are in flight (PC_LATENCY=3):
  - next cycle: IDLE, `busy=0`, `m_valid=0`;
  - a subsequent `cfg_len=1` with a word of value 1 gives `m_sum=1`, with no stale contribution.
- Max-length stress: `LEN_W=4`, `cfg_len=15`, all-ones words → `m_sum=960`, no wrap.
